// File: rtl/ddp_pkg.sv
// Shared definitions for the display data processor: colour width, black level,
// pixel classification carried down the read-latency pipeline, and a width helper.
package ddp_pkg;

  localparam int unsigned RGB_W = 12;
  localparam logic [RGB_W-1:0] RGB_BLACK = '0;

  // What the output stage should do with a pixel once its VRAM data arrives.
  typedef enum logic [1:0] {
    PixBlank  = 2'd0,
    PixBorder = 2'd1,
    PixTexel  = 2'd2
  } pix_kind_e;

  // Bits needed to hold values 0..value-1 (at least one bit).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 1;
    while ((64'd1 << width) < 64'(value)) begin
      width++;
    end
    return width;
  endfunction

endpackage

// File: rtl/ddp_edge.sv
// One-register falling-edge detector: fall_o pulses for the cycle in which d_i
// drops after having been high on the previous cycle.
module ddp_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic fall_o
);

  logic d_q;

  // Remember last cycle's level; cleared by synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_i;
    end
  end

  assign fall_o = d_q & ~d_i;

endmodule

// File: rtl/ddp_scaler.sv
// Display data processor: replicates each texel of an H_LEN x V_LEN VRAM canvas
// SCALE times in x and y, issues VRAM read addresses and aligns returned texels
// with a registered rgb output RD_LAT+1 cycles after the issuing active cycle.
// Optional feature: define DDP_SCALER_BORDER_EN to paint active pixels outside
// the canvas with BORDER_RGB; otherwise they are black.
module ddp_scaler
  import ddp_pkg::*;
#(
  parameter int unsigned       DW         = 15,
  parameter int unsigned       H_LEN      = 200,
  parameter int unsigned       V_LEN      = 150,
  parameter int unsigned       SCALE      = 4,
  parameter int unsigned       RD_LAT     = 1,
  parameter logic [RGB_W-1:0]  BORDER_RGB = 12'h000
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              hen,
  input  logic              ven,
  input  logic [RGB_W-1:0]  rdata,
  output logic [RGB_W-1:0]  rgb,
  output logic [DW-1:0]     raddr
);

  localparam int unsigned SxW  = clog2(SCALE);
  localparam int unsigned ColW = clog2(H_LEN + 1);
  localparam int unsigned RowW = clog2(V_LEN + 1);

  localparam logic [SxW-1:0]  SLast   = SxW'(SCALE - 1);
  localparam logic [ColW-1:0] ColMax  = ColW'(H_LEN);
  localparam logic [ColW-1:0] ColLast = ColW'(H_LEN - 1);
  localparam logic [RowW-1:0] RowMax  = RowW'(V_LEN);
  localparam logic [RowW-1:0] RowLast = RowW'(V_LEN - 1);
  localparam logic [DW-1:0]   LineStep = DW'(H_LEN);

`ifdef DDP_SCALER_BORDER_EN
  localparam logic [RGB_W-1:0] BorderColor = BORDER_RGB;
`else
  // Border pixels stay black; masking keeps BORDER_RGB referenced but inert.
  localparam logic [RGB_W-1:0] BorderColor = BORDER_RGB & RGB_BLACK;
`endif

  logic act, line_end, frame_end;
  assign act = hen & ven;

  ddp_edge u_act_edge (
    .clk_i  (pclk),
    .rst_i  (rst),
    .d_i    (act),
    .fall_o (line_end)
  );

  ddp_edge u_ven_edge (
    .clk_i  (pclk),
    .rst_i  (rst),
    .d_i    (ven),
    .fall_o (frame_end)
  );

  logic [SxW-1:0]  sx_q, sx_d, sy_q, sy_d;
  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;
  logic [DW-1:0]   line_base_q, line_base_d;

  // Scan bookkeeping: frame_end beats line_end, which beats pixel stepping.
  always_comb begin
    sx_d        = sx_q;
    sy_d        = sy_q;
    col_d       = col_q;
    row_d       = row_q;
    line_base_d = line_base_q;
    if (frame_end) begin
      sx_d        = '0;
      sy_d        = '0;
      col_d       = '0;
      row_d       = '0;
      line_base_d = '0;
    end else if (line_end) begin
      sx_d  = '0;
      col_d = '0;
      if (sy_q == SLast) begin
        sy_d = '0;
        if (row_q != RowMax) begin
          row_d = row_q + RowW'(1);
        end
        // Base stops at the last canvas row so overscan lines repeat it.
        if (row_q < RowLast) begin
          line_base_d = line_base_q + LineStep;
        end
      end else begin
        sy_d = sy_q + SxW'(1);
      end
    end else if (act) begin
      if (sx_q == SLast) begin
        sx_d = '0;
        if (col_q != ColMax) begin
          col_d = col_q + ColW'(1);
        end
      end else begin
        sx_d = sx_q + SxW'(1);
      end
    end
  end

  // Scan counter registers.
  always_ff @(posedge pclk) begin
    if (rst) begin
      sx_q        <= '0;
      sy_q        <= '0;
      col_q       <= '0;
      row_q       <= '0;
      line_base_q <= '0;
    end else begin
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      col_q       <= col_d;
      row_q       <= row_d;
      line_base_q <= line_base_d;
    end
  end

  logic            col_in, in_canvas;
  logic [ColW-1:0] col_clamp;
  pix_kind_e       issue_kind;

  // Address and classification of the pixel issued this cycle.
  always_comb begin
    col_in     = (col_q < ColMax);
    in_canvas  = col_in & (row_q < RowMax);
    col_clamp  = col_in ? col_q : ColLast;
    raddr      = line_base_q + DW'(col_clamp);
    issue_kind = PixBlank;
    if (act) begin
      issue_kind = in_canvas ? PixTexel : PixBorder;
    end
  end

  pix_kind_e kind_q [RD_LAT];

  // Carry the pixel class alongside the VRAM read until rdata is valid.
  always_ff @(posedge pclk) begin
    if (rst) begin
      for (int i = 0; i < int'(RD_LAT); i++) begin
        kind_q[i] <= PixBlank;
      end
    end else begin
      kind_q[0] <= issue_kind;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        kind_q[i] <= kind_q[i-1];
      end
    end
  end

  logic [RGB_W-1:0] rgb_q, rgb_d;

  // Output colour select for the pixel whose data arrives this cycle.
  always_comb begin
    case (kind_q[RD_LAT-1])
      PixTexel:  rgb_d = rdata;
      PixBorder: rgb_d = BorderColor;
      default:   rgb_d = RGB_BLACK;
    endcase
  end

  // Registered pixel output.
  always_ff @(posedge pclk) begin
    if (rst) begin
      rgb_q <= RGB_BLACK;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign rgb = rgb_q;

endmodule

// File: tb/tb_ddp_scaler.sv
// Self-checking bench for ddp_scaler: 4x3 canvas, scale 2, one-cycle VRAM that
// returns rdata = raddr. Expected pixels come from screen coordinates.
module tb_ddp_scaler;

  localparam int H   = 4;
  localparam int V   = 3;
  localparam int S   = 2;
  localparam int DWB = 4;
  localparam logic [11:0] BORDER = 12'hF00;
`ifdef DDP_SCALER_BORDER_EN
  localparam logic [11:0] ExpBorder = BORDER;
`else
  localparam logic [11:0] ExpBorder = 12'h000;
`endif

  logic            pclk = 1'b0;
  logic            rst  = 1'b1;
  logic            hen  = 1'b1;
  logic            ven  = 1'b1;
  logic [11:0]     rdata;
  logic [11:0]     rgb;
  logic [DWB-1:0]  raddr;

  int n_vec = 0;
  int n_err = 0;
  logic [11:0] sb [$];

  typedef struct {
    logic        h;
    logic        chk;
    logic [31:0] ea;
    logic [31:0] er;
  } vec_t;
  vec_t tbl [12];

  ddp_scaler #(
    .DW         (DWB),
    .H_LEN      (H),
    .V_LEN      (V),
    .SCALE      (S),
    .RD_LAT     (1),
    .BORDER_RGB (BORDER)
  ) dut (
    .pclk  (pclk),
    .rst   (rst),
    .hen   (hen),
    .ven   (ven),
    .rdata (rdata),
    .rgb   (rgb),
    .raddr (raddr)
  );

  always #5 pclk = ~pclk;

  // One-cycle VRAM whose contents equal the address.
  always_ff @(posedge pclk) rdata <= 12'(raddr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pix_addr(input int x, input int y);
    int cx;
    int cy;
    cx = x / S;
    cy = y / S;
    if (cx > H - 1) cx = H - 1;
    if (cy > V - 1) cy = V - 1;
    return 32'(cy * H + cx);
  endfunction

  function automatic logic [11:0] pix_rgb(input int x, input int y);
    if ((x / S) < H && (y / S) < V) return 12'(pix_addr(x, y));
    return ExpBorder;
  endfunction

  // One normal cycle: drive, sample mid-cycle, score rgb from two cycles back.
  task automatic cyc(input logic h, input logic v, input logic chk_a,
                     input logic [31:0] ea, input logic [11:0] er);
    @(posedge pclk); #1;
    rst = 1'b0; hen = h; ven = v;
    @(negedge pclk);
    if (chk_a) check("raddr", 32'(raddr), ea);
    sb.push_back(er);
    if (sb.size() > 2) check("rgb", 32'(rgb), 32'(sb.pop_front()));
  endtask

  task automatic do_reset(input int n, input logic h, input logic v);
    for (int i = 0; i < n; i++) begin
      @(posedge pclk); #1;
      rst = 1'b1; hen = h; ven = v;
      @(negedge pclk);
      if (i == 0) begin
        if (sb.size() >= 2) check("rgb pre-reset", 32'(rgb), 32'(sb.pop_front()));
      end else begin
        check("reset rgb", 32'(rgb), 32'd0);
        check("reset raddr", 32'(raddr), 32'd0);
      end
    end
    sb.delete();
    sb.push_back(12'h000);
    sb.push_back(12'h000);
  endtask

  task automatic run_frame(input int lines, input int nact, input int nhb,
                           input bit tight, input int nvb);
    for (int y = 0; y < lines; y++) begin
      for (int x = 0; x < nact; x++) cyc(1'b1, 1'b1, 1'b1, pix_addr(x, y), pix_rgb(x, y));
      if (!(tight && y == lines - 1)) begin
        for (int b = 0; b < nhb; b++) cyc(1'b0, 1'b1, 1'b0, 32'd0, 12'h000);
      end
    end
    for (int b = 0; b < nvb; b++) cyc(1'b0, 1'b0, 1'b0, 32'd0, 12'h000);
  endtask

  task automatic apply_table();
    for (int i = 0; i < 12; i++) begin
      @(posedge pclk); #1;
      rst = 1'b0; hen = tbl[i].h; ven = 1'b1;
      @(negedge pclk);
      if (tbl[i].chk) check($sformatf("line raddr[%0d]", i), 32'(raddr), tbl[i].ea);
      check($sformatf("line rgb[%0d]", i), 32'(rgb), tbl[i].er);
    end
    sb.delete();
    sb.push_back(12'h000);
    sb.push_back(12'h000);
  endtask

  initial begin
    // Single 8-pixel line at the top of a frame, then 4 blanking cycles.
    for (int i = 0; i < 12; i++) begin
      tbl[i].h   = (i < 8);
      tbl[i].chk = (i < 8);
      tbl[i].ea  = (i < 8) ? 32'(i / 2) : 32'd0;
      tbl[i].er  = (i >= 2 && i < 10) ? 32'((i - 2) / 2) : 32'd0;
    end

    // Reset held with act high, then one active cycle after release.
    do_reset(3, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 32'd0, 12'h000);
    cyc(1'b0, 1'b1, 1'b0, 32'd0, 12'h000);
    for (int b = 0; b < 3; b++) cyc(1'b0, 1'b0, 1'b0, 32'd0, 12'h000);

    apply_table();
    for (int b = 0; b < 3; b++) cyc(1'b0, 1'b0, 1'b0, 32'd0, 12'h000);

    // Line progression through the whole canvas.
    run_frame(6, 8, 4, 1'b0, 4);

    // Odd line count ending with ven and hen falling together, then a new frame.
    run_frame(3, 8, 3, 1'b1, 4);
    run_frame(6, 8, 3, 1'b0, 4);

    // Overscan in both axes.
    run_frame(8, 10, 3, 1'b0, 4);

    // Reset in the middle of a line at column 2, then realign on frame_end.
    for (int x = 0; x < 4; x++) cyc(1'b1, 1'b1, 1'b1, pix_addr(x, 0), pix_rgb(x, 0));
    do_reset(1, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 32'd0, 12'h000);
    for (int b = 0; b < 3; b++) cyc(1'b0, 1'b0, 1'b0, 32'd0, 12'h000);
    apply_table();
    for (int b = 0; b < 2; b++) cyc(1'b0, 1'b0, 1'b0, 32'd0, 12'h000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ddp_scaler.md
# ddp_scaler

Parametrised display data processor: maps a VRAM canvas of H_LEN×V_LEN texels onto the active display area with an integer replication factor SCALE in both axes. It sits between the VRAM read port and the display timing block (DST), forming the display unit (DU) together with it. Row/column bookkeeping is explicit, so it needs no address-arithmetic tricks. It also handles oversized active areas and VRAM read latency.

## Interface
- DW, 15: raddr width; must satisfy 2^DW ≥ H_LEN·V_LEN
- H_LEN, 200: canvas width in texels
- V_LEN, 150: canvas height in texels
- SCALE, 4: replication factor, ≥1, same in x and y
- RD_LAT, 1: VRAM read latency in pclk cycles, ≥1
- BORDER_RGB, 12'h000: colour outside the canvas region (used only with the macro)

Ports:
- pclk  in  1  pixel clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- hen  in  1  horizontal display enable
- ven  in  1  vertical display enable
- rdata  in  12  VRAM texel returned RD_LAT cycles after raddr
- rgb  out  12  pixel colour, registered
- raddr  out  DW  VRAM read address for the current screen pixel

## Operation
- act = hen & ven; act_d = act registered; line_end = act_d & ~act; frame_end = ven_d & ~ven.
- Registered state: sx (0..SCALE-1), sy (0..SCALE-1), col (0..H_LEN), row (0..V_LEN), line_base (DW bits).
- raddr = line_base + min(col, H_LEN-1). When row = V_LEN, raddr holds (V_LEN-1)·H_LEN + min(col, H_LEN-1).
- in_canvas = (col < H_LEN) & (row < V_LEN).
- On an act cycle: sx advances. When sx = SCALE-1, sx wraps to 0 and col increments, saturating at H_LEN.
- On line_end (priority below frame_end): sx, col ← 0; sy advances. When sy = SCALE-1, sy ← 0, row increments (saturating at V_LEN) and line_base += H_LEN unless row is already V_LEN-1 or higher.
- On frame_end: sx, sy, col, row, line_base ← 0. This overrides a simultaneous line_end.
- SCALE = 1: sx and sy are held at 0; col and row advance on every step.
- Nothing advances during blanking; counters hold their values.

## Timing
- Reset (cycle after rst is sampled high): rgb = 0, raddr = 0, all counters 0, act_d = ven_d = 0.
- Pixel pipeline: act and in_canvas are delayed RD_LAT+1 stages. rgb = rdata if delayed act & delayed in_canvas. Otherwise rgb = BORDER_RGB if delayed act only, and 0 in blanking.
- rgb lags the act cycle that issued raddr by RD_LAT+1 cycles. DST must delay hsync/vsync by the same amount.
- rst mid-line or mid-frame: the pipeline flushes to 0 on the next cycle. Output restarts at the top-left on release, and the next frame_end realigns the counters.
- The first frame after reset is correct only if rst is released during vertical blanking.

## Configuration
- DDP_SCALER_BORDER_EN defined: active pixels outside the canvas output BORDER_RGB.
- Not defined: those pixels output 12'h000 and the BORDER_RGB parameter is ignored.
- Address behaviour is identical in both cases.

## Structure
- Shared package ddp_pkg: RGB_W = 12, RGB_BLACK, a clog2 function for the sx/sy/col/row widths.
- Sub-module ddp_edge, instantiated twice (act, ven): one register plus a combinational falling-edge pulse output.

## Test plan
Default bench configuration: H_LEN=4, V_LEN=3, SCALE=2, RD_LAT=1, BORDER_RGB=12'hF00. The VRAM model returns rdata = raddr one cycle after each read.
- Reset: hold rst for 3 cycles with act=1 → rgb=0, raddr=0 throughout, and for 1 cycle after release.
- Single line, 8 act cycles → raddr 0,0,1,1,2,2,3,3; rgb equals that sequence delayed 2 cycles; rgb=0 in blanking.
- Line progression: lines 1–2 → texels 0..3 twice; lines 3–4 → 4..7; lines 5–6 → 8..11.
- Overscan, 10 act cycles per line, 8 lines: columns 9–10 → raddr 3, rgb 12'hF00. Lines 7–8 → raddr held at 8..11 pattern, rgb 12'hF00. Without the macro, rgb is 0 in both cases.
- Frame wrap: ven falls coincident with hen, then a new frame → first raddr 0, and frame_end takes priority (sy=0, not 1).
- Mid-line reset at col 2 → the next cycle rgb=0, raddr=0. After a frame_end, output matches the single-line scenario.
